// File: rtl/i2c_slave_regfile.sv
// I2C slave register file: a pointer byte selects a register, following write
// bytes fill successive registers, and reads stream registers out MSB-first
// from the pointer. The pointer auto-increments and wraps at NUM_REGS.
module i2c_slave_regfile #(
  parameter logic [6:0]              I2C_ADDRESS   = 7'd0,
  parameter int                      NUM_REGS      = 4,
  parameter logic [8*NUM_REGS-1:0]   DEFAULT_VALUE = '0,
  localparam int                     PW            = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           i2c_interface_rx,
  output logic [1:0]            i2c_interface_tx,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_index,
  output logic                  rd_strobe,
  output logic [PW-1:0]         pointer
);

  typedef enum logic [1:0] {IDLE, PTR, WR, RD} state_t;

  // Frontend bundle fields
  logic       rx_stop, rx_content, content_strobe, pkt_read_wr, pkt_addressed;
  logic [7:0] bit_count;
  logic [6:0] pkt_address;
  assign {rx_stop, rx_content, content_strobe, bit_count, pkt_address,
          pkt_read_wr, pkt_addressed} = i2c_interface_rx;

  state_t                      state_q;
  logic                        dev_addr_q;
  logic [7:0]                  shift_q;
  logic [PW-1:0]               pointer_q;
  logic [PW-1:0]               wr_index_q;
  logic                        wr_strobe_q, rd_strobe_q;
  logic [NUM_REGS-1:0][7:0]    regs_q;

  logic       dev_addressed;
  logic       boundary;
  logic [7:0] byte_d;
  logic       tx_content, ack;

  assign dev_addressed = pkt_addressed && (pkt_address == I2C_ADDRESS);
  // The bit arriving with bit_count[2:0]==7 is the LSB of the byte.
  assign boundary      = content_strobe && (bit_count[2:0] == 3'd7);
  assign byte_d        = {shift_q[6:0], rx_content};

  // Transaction FSM, pointer, register array and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dev_addr_q  <= 1'b0;
      shift_q     <= 8'h00;
      pointer_q   <= '0;
      wr_index_q  <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      regs_q      <= DEFAULT_VALUE;
    end else begin
      dev_addr_q  <= dev_addressed;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      if (!dev_addressed || rx_stop) begin
        // Stop or loss of address abandons any partial byte.
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (!dev_addr_q) state_q <= pkt_read_wr ? RD : PTR;
          PTR: if (content_strobe) begin
            shift_q <= byte_d;
            if (boundary) begin
              pointer_q <= byte_d[PW-1:0];
              state_q   <= WR;
            end
          end
          WR: if (content_strobe) begin
            shift_q <= byte_d;
            if (boundary) begin
              regs_q[pointer_q] <= byte_d;
              wr_strobe_q       <= 1'b1;
              wr_index_q        <= pointer_q;
              pointer_q         <= pointer_q + PW'(1);
            end
          end
          RD: if (boundary) begin
            pointer_q   <= pointer_q + PW'(1);
            rd_strobe_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Read data comes straight from the addressed register; released bus otherwise.
  assign tx_content = (state_q == RD) ? regs_q[pointer_q][3'd7 - bit_count[2:0]] : 1'b1;
  // Never ACK in a read's master ACK slot; hold the line released during reset.
  assign ack        = dev_addressed && (!pkt_read_wr || (bit_count == 8'd0)) && !reset;

  assign i2c_interface_tx = {tx_content, ack};
  assign reg_out          = regs_q;
  assign wr_strobe        = wr_strobe_q;
  assign wr_index         = wr_index_q;
  assign rd_strobe        = rd_strobe_q;
  assign pointer          = pointer_q;

endmodule
